// File: rtl/canoe_game_ctrl_if.sv
// Control/status bundle between the button front end, the rule checker and the
// canoe game sequencer.
interface canoe_game_ctrl_if;
    logic       tick;
    logic       sw6;
    logic       sw5;
    logic       go_req;
    logic       diff_next;
    logic       win_flag;
    logic       fail_flag;
    logic [1:0] game_state;
    logic [3:0] cnt_canoe;
    logic       canoe_side;
    logic       moving;
    logic [4:0] move_cnt;
    logic [1:0] difficulty;

    modport master (
        output tick, sw6, sw5, go_req, diff_next, win_flag, fail_flag,
        input  game_state, cnt_canoe, canoe_side, moving, move_cnt, difficulty
    );

    modport slave (
        input  tick, sw6, sw5, go_req, diff_next, win_flag, fail_flag,
        output game_state, cnt_canoe, canoe_side, moving, move_cnt, difficulty
    );
endinterface

// File: rtl/canoe_game_ctrl.sv
// Game sequencer for the cat-and-dog canoe crossing puzzle: state machine,
// canoe animation counter, crossing counter and difficulty selection.
module canoe_game_ctrl #(
    parameter int LIMIT_0 = 15,
    parameter int LIMIT_1 = 11,
    parameter int LIMIT_2 = 9,
    parameter int LIMIT_3 = 7
) (
    input logic              clk,
    input logic              rst_n,
    canoe_game_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_OFF, S_SETUP, S_READY, S_MOVE, S_ARRIVE, S_WON, S_LOST
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt_q, cnt_nxt;
    logic       side_q, side_nxt;
    logic [4:0] mc_q, mc_nxt;
    logic [1:0] diff_q, diff_nxt;
    logic       game_clear;
    logic [5:0] mc_inc;

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    function automatic logic [5:0] limit_of(input logic [1:0] d);
        case (d)
            2'd0:    return 6'(LIMIT_0);
            2'd1:    return 6'(LIMIT_1);
            2'd2:    return 6'(LIMIT_2);
            default: return 6'(LIMIT_3);
        endcase
    endfunction

    // Widened so the limit compare sees the true post-arrival count.
    assign mc_inc = {1'b0, mc_q} + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_OFF;
            cnt_q  <= '0;
            side_q <= 1'b0;
            mc_q   <= '0;
            diff_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt_q  <= cnt_nxt;
            side_q <= side_nxt;
            mc_q   <= mc_nxt;
            diff_q <= diff_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt_q;
        side_nxt   = side_q;
        mc_nxt     = mc_q;
        diff_nxt   = diff_q;
        game_clear = 1'b0;
        if (!bus.sw6) begin
            state_nxt  = S_OFF;
            game_clear = 1'b1;
        end else begin
            case (state)
                S_OFF: begin
                    if (bus.sw5) begin
                        state_nxt = S_SETUP;
                    end else begin
                        state_nxt  = S_READY;
                        game_clear = 1'b1;
                    end
                end
                S_SETUP: begin
                    if (bus.diff_next) diff_nxt = diff_q + 2'd1;
                    if (!bus.sw5) begin
                        state_nxt  = S_READY;
                        game_clear = 1'b1;
                    end
                end
                S_READY: begin
                    if (bus.sw5)         state_nxt = S_SETUP;
                    else if (bus.go_req) state_nxt = S_MOVE;
                end
                S_MOVE: begin
                    // Arrival is detected on the tick that lands on the far bank.
                    if (bus.tick) begin
                        if (!side_q) begin
                            cnt_nxt = cnt_q + 4'd1;
                            if (cnt_q == 4'd14) state_nxt = S_ARRIVE;
                        end else begin
                            cnt_nxt = cnt_q - 4'd1;
                            if (cnt_q == 4'd1) state_nxt = S_ARRIVE;
                        end
                    end
                end
                S_ARRIVE: begin
                    side_nxt = ~side_q;
                    mc_nxt   = sat_inc5(mc_q);
                    if (bus.fail_flag)                 state_nxt = S_LOST;
                    else if (bus.win_flag)             state_nxt = S_WON;
                    else if (mc_inc == limit_of(diff_q)) state_nxt = S_LOST;
                    else                               state_nxt = S_READY;
                end
                S_WON, S_LOST: begin
                    if (bus.sw5) begin
                        state_nxt = S_SETUP;
                    end else if (bus.go_req) begin
                        state_nxt  = S_READY;
                        game_clear = 1'b1;
                    end
                end
                default: state_nxt = S_OFF;
            endcase
        end
        if (game_clear) begin
            cnt_nxt  = '0;
            side_nxt = 1'b0;
            mc_nxt   = '0;
        end
    end

    always_comb begin
        case (state)
            S_READY, S_MOVE, S_ARRIVE: bus.game_state = 2'd2;
            S_WON:                     bus.game_state = 2'd1;
            default:                   bus.game_state = 2'd0;
        endcase
    end

    assign bus.cnt_canoe  = cnt_q;
    assign bus.canoe_side = side_q;
    assign bus.moving     = (state == S_MOVE);
    assign bus.move_cnt   = mc_q;
    assign bus.difficulty = diff_q;
endmodule

// File: tb/tb_canoe_game_ctrl.sv
// Self-checking bench for canoe_game_ctrl: directed scenarios plus randomized
// games checked against an arithmetic model of the crossing rules.
module tb_canoe_game_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   limits[4] = '{15, 11, 9, 7};
    int   model_diff = 0;

    canoe_game_ctrl_if bus();
    canoe_game_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go();
        bus.go_req = 1'b1; cyc(); bus.go_req = 1'b0;
    endtask

    task automatic pulse_diff();
        bus.diff_next = 1'b1; cyc(); bus.diff_next = 1'b0;
    endtask

    // One crossing from READY; expectations come from the crossing index.
    task automatic play_crossing(input string tag, input bit w, input bit f,
                                 input int exp_gs, input int exp_mc, input bit junk);
        int start_side, n, budget, exp_cnt;
        start_side = (exp_mc - 1) % 2;
        bus.tick = 1'($urandom_range(0, 1));
        pulse_go();
        bus.tick = 1'b0;
        checks++; if (bus.moving !== 1'b1) begin errors++; $display("FAIL %s_moving: got %0d want 1", tag, bus.moving); end
        n = 0; budget = 0;
        while (n < 15 && budget < 100) begin
            budget++;
            if (junk && $urandom_range(0, 2) == 0) begin
                bus.go_req    = 1'($urandom_range(0, 1));
                bus.diff_next = 1'($urandom_range(0, 1));
                bus.sw5       = 1'($urandom_range(0, 1));
                bus.win_flag  = 1'($urandom_range(0, 1));
                bus.fail_flag = 1'($urandom_range(0, 1));
                cyc();
                bus.go_req = 1'b0; bus.diff_next = 1'b0; bus.sw5 = 1'b0;
            end else begin
                bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
                n++;
            end
            exp_cnt = (start_side == 1) ? 15 - n : n;
            checks++; if (bus.cnt_canoe !== 4'(exp_cnt)) begin errors++; $display("FAIL %s_cnt: got %0d want %0d", tag, bus.cnt_canoe, exp_cnt); end
        end
        checks++; if (n != 15) begin errors++; $display("FAIL %s_timeout: got %0d ticks want 15", tag, n); end
        checks++; if (bus.game_state !== 2'd2 || bus.moving !== 1'b0) begin errors++; $display("FAIL %s_arrive: got gs=%0d moving=%0d want gs=2 moving=0", tag, bus.game_state, bus.moving); end
        bus.win_flag = w; bus.fail_flag = f;
        cyc();
        bus.win_flag = 1'b0; bus.fail_flag = 1'b0;
        checks++; if (bus.canoe_side !== 1'(1 - start_side)) begin errors++; $display("FAIL %s_side: got %0d want %0d", tag, bus.canoe_side, 1 - start_side); end
        checks++; if (bus.move_cnt !== 5'(exp_mc)) begin errors++; $display("FAIL %s_mc: got %0d want %0d", tag, bus.move_cnt, exp_mc); end
        checks++; if (bus.game_state !== 2'(exp_gs)) begin errors++; $display("FAIL %s_gs: got %0d want %0d", tag, bus.game_state, exp_gs); end
    endtask

    task automatic test_reset();
        bus.tick = 0; bus.sw6 = 0; bus.sw5 = 0; bus.go_req = 0;
        bus.diff_next = 0; bus.win_flag = 0; bus.fail_flag = 0;
        rst_n = 1'b0;
        cyc(); cyc();
        checks++; if ({bus.game_state, bus.cnt_canoe, bus.canoe_side, bus.moving, bus.move_cnt, bus.difficulty} !== 15'd0) begin errors++; $display("FAIL reset_outputs: got %0h want 0", {bus.game_state, bus.cnt_canoe, bus.canoe_side, bus.moving, bus.move_cnt, bus.difficulty}); end
        rst_n = 1'b1;
        cyc();
        checks++; if (bus.game_state !== 2'd0) begin errors++; $display("FAIL reset_off_hold: got %0d want 0", bus.game_state); end
    endtask

    task automatic test_ready();
        bus.sw6 = 1'b1; bus.sw5 = 1'b0;
        cyc();
        checks++; if (bus.game_state !== 2'd2) begin errors++; $display("FAIL ready_gs: got %0d want 2", bus.game_state); end
        checks++; if (bus.cnt_canoe !== 4'd0 || bus.canoe_side !== 1'b0 || bus.move_cnt !== 5'd0 || bus.moving !== 1'b0) begin errors++; $display("FAIL ready_clear: got cnt=%0d side=%0d mc=%0d mv=%0d want 0", bus.cnt_canoe, bus.canoe_side, bus.move_cnt, bus.moving); end
    endtask

    task automatic test_two_crossings();
        play_crossing("cross1", 0, 0, 2, 1, 0);
        play_crossing("cross2", 0, 0, 2, 2, 0);
    endtask

    task automatic test_difficulty();
        bus.sw5 = 1'b1; cyc();
        checks++; if (bus.game_state !== 2'd0) begin errors++; $display("FAIL setup_gs: got %0d want 0", bus.game_state); end
        pulse_go();
        checks++; if (bus.game_state !== 2'd0) begin errors++; $display("FAIL setup_go_ignored: got %0d want 0", bus.game_state); end
        for (int i = 1; i <= 4; i++) begin
            pulse_diff();
            checks++; if (bus.difficulty !== 2'(i % 4)) begin errors++; $display("FAIL diff_step%0d: got %0d want %0d", i, bus.difficulty, i % 4); end
        end
        for (int i = 0; i < 3; i++) pulse_diff();
        checks++; if (bus.difficulty !== 2'd3) begin errors++; $display("FAIL diff_set3: got %0d want 3", bus.difficulty); end
        model_diff = 3;
    endtask

    task automatic test_limit_lost();
        bus.sw5 = 1'b0; cyc();
        checks++; if (bus.game_state !== 2'd2 || bus.move_cnt !== 5'd0) begin errors++; $display("FAIL limit_start: got gs=%0d mc=%0d want 2/0", bus.game_state, bus.move_cnt); end
        for (int k = 1; k <= 7; k++) play_crossing("limit", 0, 0, (k == 7) ? 0 : 2, k, 1);
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        checks++; if (bus.cnt_canoe !== 4'd15 || bus.move_cnt !== 5'd7 || bus.game_state !== 2'd0) begin errors++; $display("FAIL lost_hold: got cnt=%0d mc=%0d gs=%0d want 15/7/0", bus.cnt_canoe, bus.move_cnt, bus.game_state); end
    endtask

    task automatic test_win_last();
        pulse_go();
        checks++; if (bus.game_state !== 2'd2 || bus.move_cnt !== 5'd0 || bus.cnt_canoe !== 4'd0 || bus.canoe_side !== 1'b0) begin errors++; $display("FAIL lost_restart: got gs=%0d mc=%0d cnt=%0d want 2/0/0", bus.game_state, bus.move_cnt, bus.cnt_canoe); end
        for (int k = 1; k <= 7; k++) play_crossing("winlast", k == 7, 0, (k == 7) ? 1 : 2, k, 0);
    endtask

    task automatic test_fail_priority();
        pulse_go();
        checks++; if (bus.game_state !== 2'd2 || bus.move_cnt !== 5'd0) begin errors++; $display("FAIL won_restart: got gs=%0d mc=%0d want 2/0", bus.game_state, bus.move_cnt); end
        play_crossing("both_flags", 1, 1, 0, 1, 0);
    endtask

    task automatic test_ignored_mid_move();
        pulse_go();
        play_crossing("pre_mid", 0, 0, 2, 1, 0);
        pulse_go();
        for (int i = 0; i < 6; i++) begin bus.tick = 1'b1; cyc(); end
        bus.tick = 1'b0;
        checks++; if (bus.cnt_canoe !== 4'd9) begin errors++; $display("FAIL mid_cnt: got %0d want 9", bus.cnt_canoe); end
        bus.go_req = 1'b1; bus.diff_next = 1'b1; bus.sw5 = 1'b1;
        cyc();
        bus.go_req = 1'b0; bus.diff_next = 1'b0; bus.sw5 = 1'b0;
        checks++; if (bus.cnt_canoe !== 4'd9 || bus.moving !== 1'b1 || bus.difficulty !== 2'd3) begin errors++; $display("FAIL mid_ignored: got cnt=%0d mv=%0d diff=%0d want 9/1/3", bus.cnt_canoe, bus.moving, bus.difficulty); end
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        checks++; if (bus.cnt_canoe !== 4'd8) begin errors++; $display("FAIL mid_continue: got %0d want 8", bus.cnt_canoe); end
        bus.sw6 = 1'b0; bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        checks++; if (bus.game_state !== 2'd0 || bus.cnt_canoe !== 4'd0 || bus.move_cnt !== 5'd0 || bus.canoe_side !== 1'b0 || bus.moving !== 1'b0) begin errors++; $display("FAIL sw6_off: got gs=%0d cnt=%0d mc=%0d side=%0d mv=%0d want 0", bus.game_state, bus.cnt_canoe, bus.move_cnt, bus.canoe_side, bus.moving); end
        checks++; if (bus.difficulty !== 2'd3) begin errors++; $display("FAIL sw6_diff_kept: got %0d want 3", bus.difficulty); end
    endtask

    task automatic test_async_reset();
        bus.sw6 = 1'b1; bus.sw5 = 1'b0; cyc();
        pulse_go();
        for (int i = 0; i < 4; i++) begin bus.tick = 1'b1; cyc(); end
        bus.tick = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({bus.game_state, bus.cnt_canoe, bus.canoe_side, bus.moving, bus.move_cnt, bus.difficulty} !== 15'd0) begin errors++; $display("FAIL async_reset: got %0h want 0", {bus.game_state, bus.cnt_canoe, bus.canoe_side, bus.moving, bus.move_cnt, bus.difficulty}); end
        cyc();
        rst_n = 1'b1;
        model_diff = 0;
    endtask

    task automatic test_random_games();
        int npress, lim, win_at, fail_at, exp_gs;
        for (int g = 0; g < 6; g++) begin
            bus.sw6 = 1'b1; bus.sw5 = 1'b1; cyc();
            checks++; if (bus.game_state !== 2'd0) begin errors++; $display("FAIL rnd%0d_setup: got %0d want 0", g, bus.game_state); end
            npress = $urandom_range(0, 5);
            for (int i = 0; i < npress; i++) pulse_diff();
            model_diff = (model_diff + npress) % 4;
            checks++; if (bus.difficulty !== 2'(model_diff)) begin errors++; $display("FAIL rnd%0d_diff: got %0d want %0d", g, bus.difficulty, model_diff); end
            bus.sw5 = 1'b0; cyc();
            checks++; if (bus.game_state !== 2'd2 || bus.move_cnt !== 5'd0) begin errors++; $display("FAIL rnd%0d_ready: got gs=%0d mc=%0d want 2/0", g, bus.game_state, bus.move_cnt); end
            lim = limits[model_diff];
            win_at = $urandom_range(1, lim + 2);
            fail_at = $urandom_range(1, lim + 3);
            for (int k = 1; k <= lim; k++) begin
                if (k == fail_at)     exp_gs = 0;
                else if (k == win_at) exp_gs = 1;
                else if (k == lim)    exp_gs = 0;
                else                  exp_gs = 2;
                play_crossing("rnd", k == win_at, k == fail_at, exp_gs, k, 1);
                if (exp_gs != 2) break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ready();
        test_two_crossings();
        test_difficulty();
        test_limit_lost();
        test_win_last();
        test_fail_priority();
        test_ignored_mid_move();
        test_async_reset();
        test_random_games();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/canoe_game_ctrl.md
Name: canoe_game_ctrl

Overview:
- Game sequencer for the cat-and-dog canoe crossing puzzle.
- Owns the game state machine, the canoe position animation, move counting and difficulty selection.
- Drives the game_state and cnt_canoe codes consumed by the LED display block (0 = all off, 1 = all on, 2 = single walking LED, shifted right by cnt_canoe from the leftmost LED).
- Sits between the debounced button/switch front end and the display logic.

Parameters:
- LIMIT_0, 15, move limit at difficulty 0 (easiest).
- LIMIT_1, 11, move limit at difficulty 1.
- LIMIT_2, 9, move limit at difficulty 2.
- LIMIT_3, 7, move limit at difficulty 3 (the minimum solution length).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tick  input  1  one-clk enable pulse at the animation step rate
- sw6  input  1  game enable switch (level)
- sw5  input  1  difficulty-setting mode switch (level)
- go_req  input  1  one-clk pulse: start crossing / restart after end of game
- diff_next  input  1  one-clk pulse: advance difficulty
- win_flag  input  1  level from the rule checker: puzzle solved
- fail_flag  input  1  level from the rule checker: illegal bank combination
- game_state  output  2  0 = off/lost, 1 = won, 2 = playing
- cnt_canoe  output  4  canoe position, 0 = left bank, 15 = right bank
- canoe_side  output  1  0 = left bank, 1 = right bank
- moving  output  1  high while in MOVE
- move_cnt  output  5  completed crossings, saturates at 31
- difficulty  output  2  current difficulty index

Behaviour:
- Reset (async, rst_n=0):
  - state=OFF, game_state=0, cnt_canoe=0, canoe_side=0, moving=0, move_cnt=0, difficulty=0.
- All outputs are registered. game_state is decoded from the state register:
  - 2 in READY, MOVE, ARRIVE
  - 1 in WON
  - 0 in OFF, SETUP, LOST
- States: OFF, SETUP, READY, MOVE, ARRIVE, WON, LOST.
- sw6=0 in any state: next state OFF. Clears cnt_canoe, canoe_side and move_cnt. difficulty is retained. This has priority over every other event.
- "Game clear" in the transitions below means: move_cnt=0, canoe_side=0, cnt_canoe=0.
- OFF:
  - sw6=1, sw5=1 -> SETUP.
  - sw6=1, sw5=0 -> READY with game clear.
- SETUP:
  - diff_next -> difficulty+1, wrapping 3->0.
  - sw5=0 -> READY with game clear.
  - go_req is ignored.
- READY:
  - sw5=1 -> SETUP.
  - Otherwise go_req -> MOVE; moving=1 from the next clk.
  - If sw5 and go_req occur in the same clk, SETUP wins.
- MOVE:
  - On each tick: cnt_canoe+1 if canoe_side=0, cnt_canoe-1 if canoe_side=1.
  - The tick that makes cnt_canoe reach 15 (or 0) moves to ARRIVE. A full crossing is exactly 15 ticks.
  - go_req, diff_next and sw5 are ignored. No wrap-around of cnt_canoe is possible.
- ARRIVE (exactly one clk):
  - canoe_side toggles; move_cnt increments (saturating).
  - Next state is chosen with priority fail_flag > win_flag > move limit:
    - fail_flag=1 -> LOST
    - else win_flag=1 -> WON
    - else (move_cnt+1) == LIMIT_[difficulty] -> LOST
    - else READY
  - A win on the last allowed move is WON.
  - win_flag and fail_flag are sampled only in this clk.
- WON / LOST:
  - Hold all outputs.
  - sw5=1 -> SETUP.
  - Otherwise go_req -> READY with game clear.
- difficulty changes only in SETUP. The limit compare uses the difficulty value current during ARRIVE.
- tick while not in MOVE has no effect.
- A tick coincident with sw6 falling is discarded.

Test Plan:
- Reset, then sw6=1, sw5=0 -> READY, game_state=2, cnt_canoe=0, canoe_side=0, move_cnt=0.
- In READY, go_req, then 15 ticks -> cnt_canoe steps 0..15. ARRIVE sets canoe_side=1, move_cnt=1, then READY. A second go_req plus 15 ticks -> cnt_canoe counts 15..0, canoe_side=0, move_cnt=2.
- In SETUP, four diff_next pulses -> difficulty 1,2,3,0. Set difficulty=3, play 7 crossings with win_flag=0, fail_flag=0 -> LOST, game_state=0. With win_flag=1 at the 7th arrival -> WON, game_state=1.
- At one arrival drive fail_flag=1 and win_flag=1 together -> LOST.
- Mid-MOVE (cnt_canoe=6):
  - go_req, diff_next and sw5=1 -> ignored, animation continues.
  - sw6=0 -> OFF next clk, cnt_canoe=0, move_cnt=0, difficulty unchanged.
- Assert rst_n=0 asynchronously mid-MOVE (between clk edges) -> all outputs are reset values immediately. In WON, go_req -> READY with move_cnt=0.
